// File: rtl/score_event_tx.sv
// Queues hit/kill events and presents at most one score level per display
// sample window, holding it stable until the display's sample (tick) cycle.
module score_event_tx #(
  parameter int unsigned SAMPLE_PERIOD = 30_000_000,
  parameter int unsigned PEND_W        = 4
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [1:0] game_state,
  input  logic       hit_evt,
  input  logic       kill_evt,
  output logic       score_h,
  output logic       score_k,
  output logic       busy,
  output logic       pend_ovf
);

  localparam logic [31:0]       TICK_CNT = 32'(SAMPLE_PERIOD);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  // 01 and 11 are the playing states; everything else clears, like the display.
  logic active;
  assign active = game_state[0];

  logic [31:0] cnt_reg, cnt_next;
  logic        score_h_reg, score_h_next;
  logic        score_k_reg, score_k_next;
  logic        busy_reg, busy_next;
  logic        pend_ovf_reg, pend_ovf_next;
  logic        tick, slot_empty;

  // Index 0 is the hit queue, index 1 the kill queue.
  logic [1:0]        evt, dec, sat_drop;
  logic [PEND_W-1:0] pend_cur  [2];
  logic [PEND_W-1:0] pend_nxt  [2];

  assign evt = {kill_evt, hit_evt};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      logic [PEND_W-1:0] pend_reg, pend_next;
      logic              drop;

      always_comb begin
        pend_next = pend_reg;
        drop      = 1'b0;
        if (evt[gi] && !dec[gi]) begin
          if (pend_reg == PEND_MAX) begin
            drop = 1'b1;
          end else begin
            pend_next = pend_reg + PEND_ONE;
          end
        end else if (!evt[gi] && dec[gi]) begin
          pend_next = pend_reg - PEND_ONE;
        end
      end

      always_ff @(posedge CLK_50M) begin
        if (RST || !active) begin
          pend_reg <= '0;
        end else begin
          pend_reg <= pend_next;
        end
      end

      assign pend_cur[gi] = pend_reg;
      assign pend_nxt[gi] = pend_next;
      assign sat_drop[gi] = drop;
    end
  endgenerate

  always_comb begin
    tick       = (cnt_reg == TICK_CNT);
    slot_empty = !score_h_reg && !score_k_reg;
    cnt_next   = tick ? 32'd0 : cnt_reg + 32'd1;

    // No load on the tick: the display is sampling the current slot then.
    dec[0] = !tick && slot_empty && (pend_cur[0] != '0);
    dec[1] = !tick && slot_empty && (pend_cur[0] == '0) && (pend_cur[1] != '0);

    score_h_next = score_h_reg;
    score_k_next = score_k_reg;
    if (tick) begin
      score_h_next = 1'b0;
      score_k_next = 1'b0;
    end else if (dec[0]) begin
      score_h_next = 1'b1;
    end else if (dec[1]) begin
      score_k_next = 1'b1;
    end

    busy_next     = score_h_next || score_k_next ||
                    (pend_nxt[0] != '0) || (pend_nxt[1] != '0);
    pend_ovf_next = pend_ovf_reg || (|sat_drop);
  end

  always_ff @(posedge CLK_50M) begin
    if (RST || !active) begin
      cnt_reg      <= '0;
      score_h_reg  <= 1'b0;
      score_k_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      pend_ovf_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      score_h_reg  <= score_h_next;
      score_k_reg  <= score_k_next;
      busy_reg     <= busy_next;
      pend_ovf_reg <= pend_ovf_next;
    end
  end

  assign score_h  = score_h_reg;
  assign score_k  = score_k_reg;
  assign busy     = busy_reg;
  assign pend_ovf = pend_ovf_reg;

endmodule

// File: tb/tb_score_event_tx.sv
// Directed bench for score_event_tx: per-window expected samples are queued
// when events are driven and popped at each tick of the bench's window count.
module tb_score_event_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gs;
  logic       hit, kill;

  logic a_h, a_k, a_busy, a_ovf;
  logic b_h, b_k, b_busy, b_ovf;
  logic obs_h, obs_k, obs_busy, obs_ovf;

  bit use_b;
  int period;
  int win;
  int n_tests, n_fail;

  typedef struct packed {logic h; logic k;} samp_t;
  localparam samp_t SAMP_H    = 2'b10;
  localparam samp_t SAMP_K    = 2'b01;
  localparam samp_t SAMP_NONE = 2'b00;
  samp_t sb[$];

  score_event_tx #(.SAMPLE_PERIOD(9), .PEND_W(4)) dut_a (
    .CLK_50M(clk), .RST(rst), .game_state(gs), .hit_evt(hit), .kill_evt(kill),
    .score_h(a_h), .score_k(a_k), .busy(a_busy), .pend_ovf(a_ovf)
  );

  score_event_tx #(.SAMPLE_PERIOD(29), .PEND_W(4)) dut_b (
    .CLK_50M(clk), .RST(rst), .game_state(gs), .hit_evt(hit), .kill_evt(kill),
    .score_h(b_h), .score_k(b_k), .busy(b_busy), .pend_ovf(b_ovf)
  );

  assign obs_h    = use_b ? b_h    : a_h;
  assign obs_k    = use_b ? b_k    : a_k;
  assign obs_busy = use_b ? b_busy : a_busy;
  assign obs_ovf  = use_b ? b_ovf  : a_ovf;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s win=%0d observed=%0b expected=%0b", tag, win, obs, exp);
    end
  endtask

  // One clock per iteration; on the tick cycle compare against the scoreboard.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      logic  was_act;
      samp_t e;
      was_act = !rst && gs[0];
      @(posedge clk);
      #1;
      if (!was_act || win == period) win = 0;
      else win++;
      check("excl", obs_h & obs_k, 1'b0);
      if (win == period) begin
        if (sb.size() > 0) e = sb.pop_front();
        else e = SAMP_NONE;
        check("tick_h", obs_h, e.h);
        check("tick_k", obs_k, e.k);
      end
    end
  endtask

  task automatic wait_win(input int target);
    int guard = 0;
    while (win != target && guard < 100) begin
      advance(1);
      guard++;
    end
    if (win != target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_win observed=%0d expected=%0d", win, target);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    hit  = 1'b0;
    kill = 1'b0;
    gs   = 2'b01;
    sb.delete();
    advance(2);
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; win = 0; period = 9; use_b = 1'b0;
    rst = 1'b1; gs = 2'b01; hit = 1'b0; kill = 1'b0;

    // Reset state
    advance(2);
    check("rst_h", obs_h, 1'b0);
    check("rst_k", obs_k, 1'b0);
    check("rst_busy", obs_busy, 1'b0);
    check("rst_ovf", obs_ovf, 1'b0);
    rst = 1'b0;

    // Single hit at cnt 2: visible cnt 4..9, cleared at next cnt 0
    wait_win(2);
    hit = 1'b1; sb.push_back(SAMP_H);
    advance(1);
    hit = 1'b0;
    check("t1_h_w3", obs_h, 1'b0);
    check("t1_busy_w3", obs_busy, 1'b1);
    repeat (6) begin
      advance(1);
      check("t1_h", obs_h, 1'b1);
      check("t1_k", obs_k, 1'b0);
      check("t1_busy", obs_busy, 1'b1);
    end
    advance(1);
    check("t1_h_clear", obs_h, 1'b0);
    check("t1_busy_clear", obs_busy, 1'b0);

    // Simultaneous hit + kill: hit window then kill window
    wait_win(1);
    hit = 1'b1; kill = 1'b1;
    sb.push_back(SAMP_H); sb.push_back(SAMP_K);
    advance(1);
    hit = 1'b0; kill = 1'b0;
    wait_win(9);
    advance(5);
    check("t2_k_mid", obs_k, 1'b1);
    check("t2_h_mid", obs_h, 1'b0);
    wait_win(9);
    advance(1);
    check("t2_k_clear", obs_k, 1'b0);
    check("t2_busy_clear", obs_busy, 1'b0);

    // Kill burst: three windows of score_k, no overflow
    wait_win(0);
    kill = 1'b1;
    repeat (3) sb.push_back(SAMP_K);
    advance(3);
    kill = 1'b0;
    advance(27);
    check("t3_sb_empty", sb.size() == 0, 1'b1);
    check("t3_k", obs_k, 1'b0);
    check("t3_busy", obs_busy, 1'b0);
    check("t3_ovf", obs_ovf, 1'b0);

    // Overflow: 20 hits into a 4-bit queue, 16 accepted
    use_b = 1'b1; period = 29;
    do_reset();
    repeat (16) sb.push_back(SAMP_H);
    hit = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      advance(1);
      check("t4_ovf", obs_ovf, j >= 17);
    end
    hit = 1'b0;
    advance(30 * 17 - 20);
    check("t4_sb_empty", sb.size() == 0, 1'b1);
    check("t4_ovf_sticky", obs_ovf, 1'b1);
    check("t4_busy", obs_busy, 1'b0);
    check("t4_h", obs_h, 1'b0);

    // Leaving active mid-window discards pending events
    use_b = 1'b0; period = 9;
    do_reset();
    hit = 1'b1;
    advance(3);
    hit = 1'b0;
    wait_win(5);
    check("t5_h_before", obs_h, 1'b1);
    check("t5_busy_before", obs_busy, 1'b1);
    gs = 2'b10;
    advance(1);
    check("t5_h_idle", obs_h, 1'b0);
    check("t5_k_idle", obs_k, 1'b0);
    check("t5_busy_idle", obs_busy, 1'b0);
    check("t5_ovf_idle", obs_ovf, 1'b0);
    gs = 2'b01;
    for (int j = 0; j < 30; j++) begin
      advance(1);
      check("t5_no_h", obs_h, 1'b0);
    end
    check("t5_busy_end", obs_busy, 1'b0);

    // Mid-window reset with events present during RST
    do_reset();
    hit = 1'b1;
    advance(1);
    hit = 1'b0;
    wait_win(6);
    check("t6_h_before", obs_h, 1'b1);
    rst = 1'b1; hit = 1'b1; kill = 1'b1;
    advance(1);
    check("t6_h_rst", obs_h, 1'b0);
    check("t6_k_rst", obs_k, 1'b0);
    check("t6_busy_rst", obs_busy, 1'b0);
    check("t6_ovf_rst", obs_ovf, 1'b0);
    advance(1);
    rst = 1'b0; hit = 1'b0; kill = 1'b0;
    advance(1);
    check("t6_h_after", obs_h, 1'b0);
    check("t6_busy_after", obs_busy, 1'b0);
    wait_win(2);
    hit = 1'b1; sb.push_back(SAMP_H);
    advance(1);
    hit = 1'b0;
    check("t6_h_w3", obs_h, 1'b0);
    advance(1);
    check("t6_h_w4", obs_h, 1'b1);
    wait_win(9);
    advance(1);
    check("t6_h_clear", obs_h, 1'b0);
    check("t6_busy_clear", obs_busy, 1'b0);
    check("t6_sb_empty", sb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
